// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and its detector bench.
package seq_pkg;

  localparam int unsigned GAP_W = 4;

  localparam logic [3:0] PAT_1011 = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage : seq_pkg

// File: rtl/seq_shift_reg.sv
// Pattern register with parallel load and rotate-left shift.
// Rotating (rather than shifting in zeros) restores the pattern after W shifts for the next copy.
module seq_shift_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o,
  output logic         next_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_i) begin
      q_q <= {q_q[W-2:0], q_q[W-1]};
    end
  end

  assign msb_o  = q_q[W-1];
  assign next_o = q_q[W-2];

endmodule : seq_shift_reg

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB first, repeated with optional idle gaps.
// dout/dout_valid are registered one cycle ahead, so the shift register always holds the bit on dout in its MSB.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             sr_load, sr_shift;
  logic             sr_msb, sr_next;

  seq_shift_reg #(
    .W (PAT_W)
  ) u_shift_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (pattern),
    .msb_o   (sr_msb),
    .next_o  (sr_next)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and next-output logic; rem_q counts copies still owed after the current one
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    dout_d    = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          sr_load   = 1'b1;
          bit_cnt_d = '0;
          rem_d     = (repeat_cnt == '0) ? '0 : repeat_cnt - CNT_W'(1);
          gap_d     = gap;
          dout_d    = pattern[PAT_W-1];
          valid_d   = 1'b1;
        end
      end

      ST_SHIFT: begin
        sr_shift = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (rem_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - CNT_W'(1);
            if (gap_q == '0) begin
              dout_d  = sr_next;
              valid_d = 1'b1;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q - GAP_W'(1);
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          dout_d    = sr_next;
          valid_d   = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_SHIFT;
          dout_d  = sr_msb;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything except reset, including a start seen in IDLE
    if (abort) begin
      state_d  = ST_IDLE;
      dout_d   = 1'b0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ready      = ready_q;

endmodule : seq_pattern_tx

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: vector table of whole transmissions plus start/abort/reset corner sequences.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ready;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  seq_pattern_tx #(
    .PAT_W (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ready      (ready),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pat;
    logic [7:0]  rep;
    logic [3:0]  gp;
    int          exp_n;
    logic [31:0] exp_tail;
    int          exp_done;
    int          exp_y;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one transmission; cycle 1 is the first cycle after acceptance
  task automatic run_vec(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g,
                         output int nbits, output logic [31:0] tail, output int done_cyc,
                         output int ycnt, output int bad);
    logic [3:0] win;
    pattern = p; repeat_cnt = r; gap = g; start = 1'b1;
    tick();
    start = 1'b0;
    nbits = 0; tail = '0; done_cyc = -1; ycnt = 0; bad = 0; win = '0;
    for (int c = 1; c <= 2000; c++) begin
      if (done) begin
        done_cyc = c;
        if (!ready || busy || dout_valid || dout) bad++;
        break;
      end
      win = {win[2:0], dout};
      if (win == PAT_1011) ycnt++;
      if (dout_valid) begin
        nbits++;
        tail = {tail[30:0], dout};
      end else if (dout) begin
        bad++;
      end
      if (!busy || ready) bad++;
      tick();
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk(nm, 32'(ready), 32'd1);
  endtask

  initial begin
    int nb, dc, yc, bd, vcnt, dcnt;
    logic [31:0] tl;

    vecs[0] = '{4'b1011, 8'd1,   4'd0,  4,    32'hB,        5,    1};
    vecs[1] = '{4'b1011, 8'd2,   4'd0,  8,    32'hBB,       9,    2};
    vecs[2] = '{4'b1011, 8'd0,   4'd0,  4,    32'hB,        5,    1};
    vecs[3] = '{4'b1011, 8'd2,   4'd3,  8,    32'hBB,       12,   2};
    vecs[4] = '{4'b0110, 8'd3,   4'd1,  12,   32'h666,      15,   0};
    vecs[5] = '{4'b1000, 8'd1,   4'd15, 4,    32'h8,        5,    0};
    vecs[6] = '{4'b1100, 8'd2,   4'd15, 8,    32'hCC,       24,   0};
    vecs[7] = '{4'b1101, 8'd2,   4'd0,  8,    32'hDD,       9,    1};
    vecs[8] = '{4'b1011, 8'd255, 4'd0,  1020, 32'hBBBBBBBB, 1021, 255};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_cnt = '0; gap = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_dout",  32'({dout, dout_valid}), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i].pat, vecs[i].rep, vecs[i].gp, nb, tl, dc, yc, bd);
      chk($sformatf("v%0d_nbits", i), 32'(nb), 32'(vecs[i].exp_n));
      chk($sformatf("v%0d_tail", i),  tl, vecs[i].exp_tail);
      chk($sformatf("v%0d_done_cyc", i), 32'(dc), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_det_y", i), 32'(yc), 32'(vecs[i].exp_y));
      chk($sformatf("v%0d_bad_cycles", i), 32'(bd), 32'd0);
      tick();
    end

    // start while busy is ignored; start in the done cycle is accepted
    pattern = 4'b1011; repeat_cnt = 8'd1; gap = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0; dc = -1;
    for (int c = 1; c <= 50; c++) begin
      if (done) begin dc = c; break; end
      if (dout_valid) nb++;
      if (c == 2) begin start = 1'b1; pattern = 4'b1111; repeat_cnt = 8'd5; end
      else start = 1'b0;
      tick();
    end
    chk("busy_start_nbits", 32'(nb), 32'd4);
    chk("busy_start_done",  32'(dc), 32'd5);
    pattern = 4'b1100; repeat_cnt = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_msb", 32'({dout_valid, dout}), 32'd3);
    tick();
    chk("done_start_b2", 32'({dout_valid, dout}), 32'd3);
    tick();
    chk("done_start_b3", 32'({dout_valid, dout}), 32'd2);
    wait_idle("done_start_idle");
    tick();

    // abort and reset on bit 3 of copy 1
    for (int k = 0; k < 2; k++) begin
      pattern = 4'b1011; repeat_cnt = 8'd2; gap = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk($sformatf("kill%0d_bit3", k), 32'({dout_valid, dout}), 32'd3);
      if (k == 0) abort = 1'b1; else reset = 1'b1;
      tick();
      abort = 1'b0; reset = 1'b0;
      chk($sformatf("kill%0d_out", k), 32'({dout_valid, dout}), 32'd0);
      chk($sformatf("kill%0d_ready", k), 32'({ready, busy, done}), 32'd4);
      vcnt = 0; dcnt = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (dout_valid) vcnt++;
        if (done) dcnt++;
      end
      chk($sformatf("kill%0d_quiet", k), 32'(vcnt + dcnt), 32'd0);
    end

    // abort beats start in IDLE
    pattern = 4'b1011; repeat_cnt = 8'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_prio", 32'({ready, busy, dout_valid}), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_pattern_tx
